// File: rtl/pb_pkg.sv
// rtl/pb_pkg.sv - shared widths, mode encoding and command record for the rectangle engine
package pb_pkg;

  // Command fields are sized for the largest supported screen; the engine
  // zero-extends its resolution-specific ports into them.
  localparam int X_W  = 12;
  localparam int Y_W  = 12;
  localparam int C_W  = 16;
  // Room for x+w / y+h without overflow.
  localparam int XS_W = X_W + 2;
  localparam int YS_W = Y_W + 2;

  typedef enum logic {
    MODE_FILL    = 1'b0,
    MODE_OUTLINE = 1'b1
  } mode_e;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [X_W:0]   w;
    logic [Y_W:0]   h;
    logic [C_W-1:0] colour;
    mode_e          mode;
  } rect_cmd_t;

endpackage

// File: rtl/pb_cmd_fifo.sv
// rtl/pb_cmd_fifo.sv - synchronous command FIFO of rect_cmd_t with full/empty flags
module pb_cmd_fifo
  import pb_pkg::*;
#(
  parameter int AW = 2
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_push,
  input  rect_cmd_t i_data,
  input  logic      i_pop,
  output rect_cmd_t o_data,
  output logic      o_full,
  output logic      o_empty
);

  rect_cmd_t      r_mem [2**AW];
  logic [AW:0]    r_wr;
  logic [AW:0]    r_rd;
  logic           w_push;
  logic           w_pop;

  // Extra pointer bit tells full from empty when the indices coincide.
  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_data  = r_mem[r_rd[AW-1:0]];

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Storage write; contents need no reset because the pointers gate reads.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr[AW-1:0]] <= i_data;
    end
  end

  // Pointer update; reset flushes the queue.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

endmodule

// File: rtl/pb_rect_engine.sv
// rtl/pb_rect_engine.sv - clipped rectangle fill/outline writer for the pixel-buffer port
module pb_rect_engine
  import pb_pkg::*;
#(
  parameter int H_RES   = 160,
  parameter int V_RES   = 120,
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 15,
  parameter int FIFO_AW = 2
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [$clog2(H_RES)-1:0]   cmd_x,
  input  logic [$clog2(V_RES)-1:0]   cmd_y,
  input  logic [$clog2(H_RES):0]     cmd_w,
  input  logic [$clog2(V_RES):0]     cmd_h,
  input  logic [DATA_W-1:0]          cmd_colour,
  input  logic                       cmd_mode,
  output logic [ADDR_W-1:0]          pb_adr_export,
  output logic [DATA_W-1:0]          pb_data_export,
  output logic                       pb_we,
  input  logic                       pb_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       clipped
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_DONE} state_e;

  localparam logic [XS_W-1:0]   H_S   = XS_W'(H_RES);
  localparam logic [YS_W-1:0]   V_S   = YS_W'(V_RES);
  localparam logic [ADDR_W-1:0] H_ADR = ADDR_W'(H_RES);

  state_e            r_state, w_state_next;
  rect_cmd_t         w_cmd_in, w_head;
  logic              w_full, w_empty, w_push, w_pop;
  logic              w_unused_head;

  logic [XS_W-1:0]   w_xe, w_x1;
  logic [YS_W-1:0]   w_ye, w_y1;
  logic              w_empty_cmd, w_clip_cmd;
  logic [ADDR_W-1:0] w_start;

  logic [X_W-1:0]    r_x, r_cx;
  logic [Y_W-1:0]    r_y, r_cy;
  logic [XS_W-1:0]   r_x1, r_xr;
  logic [YS_W-1:0]   r_y1, r_ylast;
  logic              r_right, r_outline, r_clip;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_colour;

  logic [XS_W-1:0]   w_cx_s, w_cx_inc;
  logic [YS_W-1:0]   w_cy_s;
  logic              w_full_row, w_more_col, w_more_row, w_accept;
  logic [X_W-1:0]    w_next_cx;
  logic [ADDR_W-1:0] w_adr_col, w_adr_row;

  // Widen the port fields into the shared command record.
  always_comb begin
    w_cmd_in        = '0;
    w_cmd_in.x      = X_W'(cmd_x);
    w_cmd_in.y      = Y_W'(cmd_y);
    w_cmd_in.w      = (X_W+1)'(cmd_w);
    w_cmd_in.h      = (Y_W+1)'(cmd_h);
    w_cmd_in.colour = C_W'(cmd_colour);
    w_cmd_in.mode   = mode_e'(cmd_mode);
  end

  assign w_push    = cmd_valid && !w_full;
  assign cmd_ready = !w_full;
  assign w_pop     = (r_state == S_LOAD);

  pb_cmd_fifo #(.AW(FIFO_AW)) u_fifo (
    .i_clk   (clk_clk),
    .i_rst   (reset_reset),
    .i_push  (w_push),
    .i_data  (w_cmd_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Colour bits above DATA_W are always zero; fold them away here.
  assign w_unused_head = ^w_head;

  // Per-command geometry, evaluated on the FIFO head during LOAD.
  assign w_xe        = XS_W'(w_head.x) + XS_W'(w_head.w);
  assign w_ye        = YS_W'(w_head.y) + YS_W'(w_head.h);
  assign w_x1        = (w_xe > H_S) ? H_S : w_xe;
  assign w_y1        = (w_ye > V_S) ? V_S : w_ye;
  assign w_empty_cmd = (w_head.w == '0) || (w_head.h == '0) ||
                       (XS_W'(w_head.x) >= H_S) || (YS_W'(w_head.y) >= V_S);
  assign w_clip_cmd  = (w_xe > H_S) || (w_ye > V_S);
  assign w_start     = ADDR_W'(w_head.y) * H_ADR + ADDR_W'(w_head.x);

  // Raster stepping: next column (or the right-edge jump on outline interior rows) and next row.
  assign w_cx_s     = XS_W'(r_cx);
  assign w_cx_inc   = w_cx_s + XS_W'(1);
  assign w_cy_s     = YS_W'(r_cy);
  assign w_full_row = !r_outline || (r_cy == r_y) || (w_cy_s == r_ylast);
  assign w_more_col = w_full_row ? (w_cx_inc < r_x1) : ((r_cx == r_x) && r_right);
  assign w_next_cx  = w_full_row ? X_W'(w_cx_inc) : X_W'(r_xr);
  assign w_more_row = (w_cy_s + YS_W'(1)) < r_y1;
  assign w_adr_col  = r_adr + ADDR_W'(w_next_cx) - ADDR_W'(r_cx);
  assign w_adr_row  = r_adr - (ADDR_W'(r_cx) - ADDR_W'(r_x)) + H_ADR;
  assign w_accept   = (r_state == S_DRAW) && pb_ready;

  // State register.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) r_state <= S_IDLE;
    else             r_state <= w_state_next;
  end

  // Next-state logic; a push in the same cycle counts as a pending command.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (!w_empty || w_push) w_state_next = S_LOAD;
      S_LOAD: w_state_next = w_empty_cmd ? S_DONE : S_DRAW;
      S_DRAW: if (w_accept && !w_more_col && !w_more_row) w_state_next = S_DONE;
      S_DONE: w_state_next = (!w_empty || w_push) ? S_LOAD : S_IDLE;
    endcase
  end

  // Command latch in LOAD and address/cursor advance on each accepted write.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_x       <= '0;
      r_y       <= '0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_x1      <= '0;
      r_y1      <= '0;
      r_xr      <= '0;
      r_ylast   <= '0;
      r_right   <= 1'b0;
      r_outline <= 1'b0;
      r_clip    <= 1'b0;
      r_adr     <= '0;
      r_colour  <= '0;
    end else if (r_state == S_LOAD) begin
      r_x       <= w_head.x;
      r_y       <= w_head.y;
      r_cx      <= w_head.x;
      r_cy      <= w_head.y;
      r_x1      <= w_x1;
      r_y1      <= w_y1;
      r_xr      <= w_xe - XS_W'(1);
      r_ylast   <= w_ye - YS_W'(1);
      r_right   <= (w_xe <= H_S) && (w_head.w > (X_W+1)'(1));
      r_outline <= (w_head.mode == MODE_OUTLINE);
      r_clip    <= w_empty_cmd || w_clip_cmd;
      r_adr     <= w_start;
      r_colour  <= DATA_W'(w_head.colour);
    end else if (w_accept) begin
      if (w_more_col) begin
        r_cx  <= w_next_cx;
        r_adr <= w_adr_col;
      end else if (w_more_row) begin
        r_cx  <= r_x;
        r_cy  <= r_cy + Y_W'(1);
        r_adr <= w_adr_row;
      end
    end
  end

  assign pb_we          = (r_state == S_DRAW);
  assign pb_adr_export  = r_adr;
  assign pb_data_export = r_colour;
  assign done           = (r_state == S_DONE);
  assign clipped        = (r_state == S_DONE) && r_clip;
  assign busy           = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_pb_rect_engine.sv
// tb/tb_pb_rect_engine.sv - directed table-driven bench for pb_rect_engine
module tb_pb_rect_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_x;
  logic [6:0]  cmd_y;
  logic [8:0]  cmd_w;
  logic [7:0]  cmd_h;
  logic [3:0]  cmd_colour;
  logic        cmd_mode;
  logic [14:0] pb_adr;
  logic [3:0]  pb_data;
  logic        pb_we, pb_ready, busy, done, clipped;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int x; int y; int w; int h; int colour; int mode; int n; int clip;
  } vec_t;

  vec_t vecs [10];
  int   exp_adr [$];

  always #5 clk = ~clk;

  pb_rect_engine #(
    .H_RES(160), .V_RES(120), .DATA_W(4), .ADDR_W(15), .FIFO_AW(2)
  ) dut (
    .clk_clk        (clk),
    .reset_reset    (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_x          (cmd_x),
    .cmd_y          (cmd_y),
    .cmd_w          (cmd_w),
    .cmd_h          (cmd_h),
    .cmd_colour     (cmd_colour),
    .cmd_mode       (cmd_mode),
    .pb_adr_export  (pb_adr),
    .pb_data_export (pb_data),
    .pb_we          (pb_we),
    .pb_ready       (pb_ready),
    .busy           (busy),
    .done           (done),
    .clipped        (clipped)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic drive_cmd(input int x, input int y, input int w, input int h,
                           input int c, input int m);
    cmd_x      = 8'(x);
    cmd_y      = 7'(y);
    cmd_w      = 9'(w);
    cmd_h      = 8'(h);
    cmd_colour = 4'(c);
    cmd_mode   = 1'(m);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int off;
    rst = 1'b1; cmd_valid = 1'b0; pb_ready = 1'b1;
    drive_cmd(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_pb_we", pb_we, 0);
    chk("rst_adr", pb_adr, 0);
    chk("rst_data", pb_data, 0);
    chk("rst_done", done, 0);
    chk("rst_clipped", clipped, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    rst = 1'b0;

    // {x, y, w, h, colour, mode, writes, clipped}
    vecs[0] = '{2, 3, 3, 2, 5, 0, 6, 0};
    vecs[1] = '{0, 0, 4, 3, 9, 1, 10, 0};
    vecs[2] = '{158, 119, 5, 5, 3, 0, 2, 1};
    vecs[3] = '{10, 10, 0, 3, 2, 0, 0, 1};
    vecs[4] = '{5, 1, 1, 3, 6, 1, 3, 0};
    vecs[5] = '{7, 0, 3, 1, 4, 1, 3, 0};
    vecs[6] = '{158, 118, 4, 4, 12, 1, 3, 1};
    vecs[7] = '{1, 1, 3, 3, 15, 1, 8, 0};
    vecs[8] = '{160, 5, 2, 2, 1, 0, 0, 1};
    vecs[9] = '{159, 119, 1, 1, 8, 0, 1, 0};
    exp_adr = '{482, 483, 484, 642, 643, 644,
                0, 1, 2, 3, 160, 163, 320, 321, 322, 323,
                19198, 19199,
                165, 325, 485,
                7, 8, 9,
                19038, 19039, 19198,
                161, 162, 163, 321, 323, 481, 482, 483,
                19199};

    off = 0;
    for (int i = 0; i < 10; i++) begin
      int nw, first, last, dcyc, dclip;
      bit got_done;
      @(negedge clk);
      chk($sformatf("v%0d_cmd_ready", i), cmd_ready, 1);
      drive_cmd(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].colour, vecs[i].mode);
      cmd_valid = 1'b1;
      nw = 0; first = -1; last = -1; dcyc = -1; dclip = -1; got_done = 1'b0;
      for (int cyc = 1; cyc <= 60 && !got_done; cyc++) begin
        @(negedge clk);
        cmd_valid = 1'b0;
        if (pb_we) begin
          if (nw < vecs[i].n)
            chk($sformatf("v%0d_adr%0d", i, nw), pb_adr, exp_adr[off + nw]);
          chk($sformatf("v%0d_data%0d", i, nw), pb_data, vecs[i].colour);
          if (first < 0) first = cyc;
          last = cyc;
          nw++;
        end
        if (done) begin
          got_done = 1'b1;
          dcyc = cyc;
          dclip = clipped;
        end
      end
      chk($sformatf("v%0d_done_seen", i), got_done, 1);
      chk($sformatf("v%0d_nwrites", i), nw, vecs[i].n);
      if (vecs[i].n > 0) begin
        chk($sformatf("v%0d_first_we_cycle", i), first, 2);
        chk($sformatf("v%0d_done_cycle", i), dcyc, last + 1);
      end else begin
        chk($sformatf("v%0d_done_cycle", i), dcyc, 2);
      end
      chk($sformatf("v%0d_clipped", i), dclip, vecs[i].clip);
      off += vecs[i].n;
    end

    // 4x4 fill at (10,20) under pseudo-random back-pressure.
    begin
      logic [7:0]  lfsr;
      int          accepted;
      bit          stalled, got_done;
      logic [14:0] held_adr;
      logic [3:0]  held_data;
      lfsr = 8'hA5; accepted = 0; stalled = 1'b0; got_done = 1'b0;
      held_adr = '0; held_data = '0;
      @(negedge clk);
      drive_cmd(10, 20, 4, 4, 7, 0);
      cmd_valid = 1'b1;
      for (int cyc = 1; cyc <= 200 && !got_done; cyc++) begin
        @(negedge clk);
        cmd_valid = 1'b0;
        if (stalled) begin
          chk("stall_hold_we", pb_we, 1);
          chk("stall_hold_adr", pb_adr, held_adr);
          chk("stall_hold_data", pb_data, held_data);
        end
        lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        pb_ready = lfsr[0];
        stalled = pb_we && !pb_ready;
        held_adr = pb_adr;
        held_data = pb_data;
        if (pb_we && pb_ready) begin
          chk($sformatf("stall_adr%0d", accepted), pb_adr,
              (20 + accepted / 4) * 160 + 10 + accepted % 4);
          chk($sformatf("stall_data%0d", accepted), pb_data, 7);
          accepted++;
        end
        if (done) got_done = 1'b1;
      end
      pb_ready = 1'b1;
      chk("stall_accepted", accepted, 16);
      chk("stall_done_seen", got_done, 1);
    end

    // Five 4x1 fills pushed back-to-back into a depth-4 FIFO.
    begin
      int pushed, writes, dones, last_w;
      pushed = 0; writes = 0; dones = 0; last_w = -100;
      @(negedge clk);
      for (int it = 0; it < 150 && dones < 5; it++) begin
        if (it > 0) @(negedge clk);
        if (it == 5) chk("b2b_ready_low_when_full", cmd_ready, 0);
        if (pb_we) begin
          int k, j;
          k = writes / 4;
          j = writes % 4;
          chk($sformatf("b2b_adr%0d", writes), pb_adr, k * 160 + k * 10 + j);
          chk($sformatf("b2b_data%0d", writes), pb_data, k + 1);
          if (j == 0 && k > 0) chk($sformatf("b2b_gap%0d", k), it - last_w, 3);
          last_w = it;
          writes++;
        end
        if (done) dones++;
        if (pushed < 5 && cmd_ready) begin
          drive_cmd(pushed * 10, pushed, 4, 1, pushed + 1, 0);
          cmd_valid = 1'b1;
          pushed++;
        end else begin
          cmd_valid = 1'b0;
        end
      end
      cmd_valid = 1'b0;
      chk("b2b_pushed", pushed, 5);
      chk("b2b_writes", writes, 20);
      chk("b2b_dones", dones, 5);
      @(negedge clk);
      chk("b2b_busy_end", busy, 0);
    end

    // Reset mid-draw with two commands queued behind the active one.
    begin
      int we_cnt, done_cnt;
      for (int it = 0; it <= 5; it++) begin
        @(negedge clk);
        if (it < 3) begin
          drive_cmd(0, 50 + it * 10, 10, 10, 3 + it, 0);
          cmd_valid = 1'b1;
        end else begin
          cmd_valid = 1'b0;
        end
      end
      chk("rst_mid_we_before", pb_we, 1);
      chk("rst_mid_busy_before", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_we", pb_we, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_cmd_ready", cmd_ready, 1);
      chk("rst_mid_done", done, 0);
      we_cnt = 0; done_cnt = 0;
      for (int it = 0; it < 30; it++) begin
        @(negedge clk);
        if (pb_we) we_cnt++;
        if (done) done_cnt++;
      end
      chk("rst_mid_no_writes", we_cnt, 0);
      chk("rst_mid_no_done", done_cnt, 0);
      chk("rst_mid_busy_end", busy, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
